// File: rtl/rfoc_pkg.sv
// Shared types and helpers for the banked register file / operand collector.
package rfoc_pkg;

    typedef enum logic [1:0] {
        CU_FREE,
        CU_COLLECT,
        CU_READY
    } cu_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int data_width(input int lanes);
        return lanes * 32;
    endfunction

    // Skewing the bank by warp spreads the same register of different warps across banks.
    function automatic int bank_of(input int warp, input int rid, input int nbanks);
        return (warp + rid) % nbanks;
    endfunction

endpackage

// File: rtl/rfoc_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, which moves just past the last winner.
module rfoc_rr_arb #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          found;

    always_comb begin
        int k;
        gnt   = '0;
        found = 1'b0;
        win   = ptr;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (en && !found && req[IW'(k)]) begin
                gnt[IW'(k)] = 1'b1;
                found       = 1'b1;
                win         = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/rfoc_banked.sv
// Banked per-warp vector register file with NUM_CU operand collectors feeding EX oldest-first.
module rfoc_banked
    import rfoc_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int NUM_REGS  = 16,
    parameter int LANES     = 8,
    parameter int NUM_BANKS = 4,
    parameter int NUM_CU    = 4,
    parameter int TAG_W     = 64,
    localparam int WID_W = clog2_min1(NUM_WARPS),
    localparam int RID_W = clog2_min1(NUM_REGS),
    localparam int DW    = data_width(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             full_oc_ib,
    input  logic [WID_W-1:0] in_warp,
    input  logic [RID_W-1:0] in_src1,
    input  logic [RID_W-1:0] in_src2,
    input  logic             in_src1_valid,
    input  logic             in_src2_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             wb_valid,
    input  logic [WID_W-1:0] wb_warp,
    input  logic [RID_W-1:0] wb_reg,
    input  logic [LANES-1:0] wb_mask,
    input  logic [DW-1:0]    wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WID_W-1:0] out_warp,
    output logic [TAG_W-1:0] out_tag,
    output logic [DW-1:0]    out_data1,
    output logic [DW-1:0]    out_data2
);

    localparam int BW    = clog2_min1(NUM_BANKS);
    localparam int SHIFT = $clog2(NUM_BANKS);
    localparam int ROWS  = NUM_WARPS * NUM_REGS / NUM_BANKS;
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int CU_W  = clog2_min1(NUM_CU);
    localparam int AGE_W = clog2_min1(NUM_CU) + 2;

    // Dropping the low bits of {warp, reg} is unique within a bank because the bank skew covers them.
    function automatic logic [ROW_W-1:0] row_of(input logic [WID_W-1:0] w, input logic [RID_W-1:0] r);
        logic [WID_W+RID_W-1:0] full;
        full = {w, r};
        return ROW_W'(full >> SHIFT);
    endfunction

    function automatic logic [BW-1:0] bank_idx(input logic [WID_W-1:0] w, input logic [RID_W-1:0] r);
        return BW'(bank_of(int'(w), int'(r), NUM_BANKS));
    endfunction

    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    logic [NUM_CU-1:0] cu_free;
    logic [NUM_CU-1:0] cu_ready;
    logic [NUM_CU-1:0] need1;
    logic [NUM_CU-1:0] need2;
    logic [BW-1:0]     bank1    [NUM_CU];
    logic [BW-1:0]     bank2    [NUM_CU];
    logic [ROW_W-1:0]  row1     [NUM_CU];
    logic [ROW_W-1:0]  row2     [NUM_CU];
    logic [WID_W-1:0]  cu_warp  [NUM_CU];
    logic [TAG_W-1:0]  cu_tag   [NUM_CU];
    logic [DW-1:0]     cu_data1 [NUM_CU];
    logic [DW-1:0]     cu_data2 [NUM_CU];
    logic [AGE_W-1:0]  cu_age   [NUM_CU];
    logic [NUM_CU-1:0] gnt      [NUM_BANKS];
    logic [DW-1:0]     rd_data  [NUM_BANKS];

    logic              accept;
    logic [NUM_CU-1:0] acc_onehot;
    logic              acc_found;
    logic [AGE_W-1:0]  acc_cnt;
    logic              disp_any;
    logic [CU_W-1:0]   disp_idx;
    logic              out_load;
    logic              disp_fire;
    logic [BW-1:0]     wb_bank;
    logic [ROW_W-1:0]  wb_row;

    assign in_ready  = |cu_free;
    assign accept    = in_valid && in_ready;
    assign out_load  = !out_valid || out_ready;
    assign disp_fire = out_load && disp_any;
    assign wb_bank   = bank_idx(wb_warp, wb_reg);
    assign wb_row    = row_of(wb_warp, wb_reg);

    always_comb begin
        acc_onehot = '0;
        acc_found  = 1'b0;
        for (int c = 0; c < NUM_CU; c++) begin
            if (cu_free[c] && !acc_found) begin
                acc_onehot[c] = accept;
                acc_found     = 1'b1;
            end
        end
    end

    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        for (int c = 0; c < NUM_CU; c++) begin
            if (cu_ready[c] && (!disp_any || older(cu_age[c], cu_age[disp_idx]))) begin
                disp_any = 1'b1;
                disp_idx = CU_W'(c);
            end
        end
    end

    // The output register doubles as one extra slot: a CU is released as soon as it loads here.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_warp   <= '0;
            out_tag    <= '0;
            out_data1  <= '0;
            out_data2  <= '0;
            full_oc_ib <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            full_oc_ib <= ~in_ready;
            if (accept) acc_cnt <= acc_cnt + 1'b1;
            if (out_load) begin
                out_valid <= disp_any;
                if (disp_any) begin
                    out_warp  <= cu_warp[disp_idx];
                    out_tag   <= cu_tag[disp_idx];
                    out_data1 <= cu_data1[disp_idx];
                    out_data2 <= cu_data2[disp_idx];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [BW-1:0] MY_BANK = BW'(b);

        logic [DW-1:0]     mem [ROWS];
        logic [NUM_CU-1:0] req;
        logic [ROW_W-1:0]  rd_row;
        logic              wr_hit;

        assign wr_hit = wb_valid && (wb_bank == MY_BANK);

        always_comb begin
            for (int c = 0; c < NUM_CU; c++) begin
                req[c] = (need1[c] && bank1[c] == MY_BANK) || (need2[c] && bank2[c] == MY_BANK);
            end
        end

        // src1 owns the bank first when both operands of a CU live here.
        always_comb begin
            rd_row = '0;
            for (int c = 0; c < NUM_CU; c++) begin
                if (gnt[b][c]) rd_row = (need1[c] && bank1[c] == MY_BANK) ? row1[c] : row2[c];
            end
        end

        rfoc_rr_arb #(.N(NUM_CU)) u_arb (
            .clk (clk),
            .rst (rst),
            .en  (!wr_hit),
            .req (req),
            .gnt (gnt[b])
        );

        assign rd_data[b] = mem[rd_row];

        always_ff @(posedge clk) begin
            if (wr_hit) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wb_mask[l]) mem[wb_row][l*32 +: 32] <= wb_data[l*32 +: 32];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CU; g++) begin : g_cu
        localparam logic [CU_W-1:0] MY_CU = CU_W'(g);

        cu_state_e        state;
        logic [WID_W-1:0] warp;
        logic [RID_W-1:0] src1;
        logic [RID_W-1:0] src2;
        logic             v1;
        logic             v2;
        logic             got1;
        logic             got2;
        logic             dup;
        logic [DW-1:0]    data1;
        logic [DW-1:0]    data2;
        logic [TAG_W-1:0] tag;
        logic [AGE_W-1:0] age;
        logic             take1;
        logic             take2;
        logic             done1;
        logic             done2;

        assign cu_free[g]  = (state == CU_FREE);
        assign cu_ready[g] = (state == CU_READY);
        assign need1[g]    = (state == CU_COLLECT) && v1 && !got1;
        assign need2[g]    = (state == CU_COLLECT) && v2 && !got2 && !dup;
        assign bank1[g]    = bank_idx(warp, src1);
        assign bank2[g]    = bank_idx(warp, src2);
        assign row1[g]     = row_of(warp, src1);
        assign row2[g]     = row_of(warp, src2);
        assign cu_warp[g]  = warp;
        assign cu_tag[g]   = tag;
        assign cu_data1[g] = data1;
        assign cu_data2[g] = data2;
        assign cu_age[g]   = age;

        assign take1 = need1[g] && gnt[bank1[g]][g];
        assign take2 = need2[g] && gnt[bank2[g]][g] && !(need1[g] && bank1[g] == bank2[g]);
        assign done1 = !v1 || got1 || take1;
        assign done2 = !v2 || got2 || take2 || (dup && take1);

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= CU_FREE;
            end else begin
                case (state)
                    CU_FREE: begin
                        if (acc_onehot[g]) begin
                            warp  <= in_warp;
                            src1  <= in_src1;
                            src2  <= in_src2;
                            v1    <= in_src1_valid;
                            v2    <= in_src2_valid;
                            dup   <= in_src1_valid && in_src2_valid && (in_src1 == in_src2);
                            got1  <= 1'b0;
                            got2  <= 1'b0;
                            data1 <= '0;
                            data2 <= '0;
                            tag   <= in_tag;
                            age   <= acc_cnt;
                            state <= (in_src1_valid || in_src2_valid) ? CU_COLLECT : CU_READY;
                        end
                    end
                    CU_COLLECT: begin
                        if (take1) begin
                            data1 <= rd_data[bank1[g]];
                            got1  <= 1'b1;
                            if (dup) begin
                                data2 <= rd_data[bank1[g]];
                                got2  <= 1'b1;
                            end
                        end
                        if (take2) begin
                            data2 <= rd_data[bank2[g]];
                            got2  <= 1'b1;
                        end
                        if (done1 && done2) state <= CU_READY;
                    end
                    CU_READY: begin
                        if (disp_fire && disp_idx == MY_CU) state <= CU_FREE;
                    end
                    default: state <= CU_FREE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rfoc_banked.sv
// Directed bench for rfoc_banked: latency, bank conflicts, writeback stalls, ordering and reset.
module tb_rfoc_banked;

    localparam int WID_W = 3;
    localparam int RID_W = 4;
    localparam int LANES = 8;
    localparam int DW    = 256;
    localparam int TAG_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             full_oc_ib;
    logic [WID_W-1:0] in_warp;
    logic [RID_W-1:0] in_src1;
    logic [RID_W-1:0] in_src2;
    logic             in_src1_valid;
    logic             in_src2_valid;
    logic [TAG_W-1:0] in_tag;
    logic             wb_valid;
    logic [WID_W-1:0] wb_warp;
    logic [RID_W-1:0] wb_reg;
    logic [LANES-1:0] wb_mask;
    logic [DW-1:0]    wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WID_W-1:0] out_warp;
    logic [TAG_W-1:0] out_tag;
    logic [DW-1:0]    out_data1;
    logic [DW-1:0]    out_data2;

    int checks = 0;
    int errors = 0;

    rfoc_banked dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .full_oc_ib    (full_oc_ib),
        .in_warp       (in_warp),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .in_src1_valid (in_src1_valid),
        .in_src2_valid (in_src2_valid),
        .in_tag        (in_tag),
        .wb_valid      (wb_valid),
        .wb_warp       (wb_warp),
        .wb_reg        (wb_reg),
        .wb_mask       (wb_mask),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_warp      (out_warp),
        .out_tag       (out_tag),
        .out_data1     (out_data1),
        .out_data2     (out_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [31:0] w);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*32 +: 32] = w;
        return r;
    endfunction

    function automatic logic [DW-1:0] lanes_from(input logic [31:0] base);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*32 +: 32] = base + 32'(l);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [WID_W-1:0] w, input logic [RID_W-1:0] r,
                            input logic [LANES-1:0] m, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_warp  = w;
        wb_reg   = r;
        wb_mask  = m;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic issue(input logic [WID_W-1:0] w, input logic [RID_W-1:0] s1, input logic v1,
                         input logic [RID_W-1:0] s2, input logic v2, input logic [TAG_W-1:0] tag);
        int n;
        in_valid      = 1'b1;
        in_warp       = w;
        in_src1       = s1;
        in_src1_valid = v1;
        in_src2       = s2;
        in_src2_valid = v2;
        in_tag        = tag;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_wait tag %0h: in_ready=%0b required 1", tag, in_ready);
        end
        step();
        in_valid      = 1'b0;
        in_src1_valid = 1'b0;
        in_src2_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
        checks++; if (full_oc_ib !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b required 0", full_oc_ib); end
        checks++; if (out_tag !== '0) begin errors++; $display("[TB] FAIL reset_out_tag: got %0h required 0", out_tag); end
        checks++; if (out_data1 !== '0 || out_warp !== '0) begin errors++; $display("[TB] FAIL reset_out_data: data1 %0h warp %0h required 0", out_data1, out_warp); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_src();
        int lat;
        wb_write(3'd2, 4'd3, 8'hFF, rep(32'h3));
        issue(3'd2, 4'd3, 1'b1, 4'd0, 1'b0, 64'hAB);
        wait_out(1, lat);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL single_latency: got %0d required 3", lat); end
        checks++; if (out_data1 !== rep(32'h3)) begin errors++; $display("[TB] FAIL single_data1: got %0h required %0h", out_data1, rep(32'h3)); end
        checks++; if (out_data2 !== '0) begin errors++; $display("[TB] FAIL single_data2: got %0h required 0", out_data2); end
        checks++; if (out_tag !== 64'hAB) begin errors++; $display("[TB] FAIL single_tag: got %0h required ab", out_tag); end
        checks++; if (out_warp !== 3'd2) begin errors++; $display("[TB] FAIL single_warp: got %0d required 2", out_warp); end
        step();
    endtask

    task automatic test_bank_conflict();
        int lat;
        wb_write(3'd0, 4'd0, 8'hFF, rep(32'h10));
        wb_write(3'd0, 4'd4, 8'hFF, rep(32'h14));
        wb_write(3'd0, 4'd1, 8'hFF, rep(32'h11));
        issue(3'd0, 4'd0, 1'b1, 4'd4, 1'b1, 64'h21);
        wait_out(1, lat);
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL conflict_latency: got %0d required 4", lat); end
        checks++; if (out_data1 !== rep(32'h10)) begin errors++; $display("[TB] FAIL conflict_data1: got %0h required %0h", out_data1, rep(32'h10)); end
        checks++; if (out_data2 !== rep(32'h14)) begin errors++; $display("[TB] FAIL conflict_data2: got %0h required %0h", out_data2, rep(32'h14)); end
        step();
        issue(3'd0, 4'd0, 1'b1, 4'd1, 1'b1, 64'h22);
        wait_out(1, lat);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL dual_bank_latency: got %0d required 3", lat); end
        checks++; if (out_data2 !== rep(32'h11) || out_tag !== 64'h22) begin errors++; $display("[TB] FAIL dual_bank_data: got %0h tag %0h required %0h tag 22", out_data2, out_tag, rep(32'h11)); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [TAG_W-1:0] exp_tag [5];
        exp_tag = '{64'h31, 64'h32, 64'h33, 64'h34, 64'h35};
        out_ready = 1'b0;
        issue(3'd2, 4'd3, 1'b1, 4'd0, 1'b0, 64'h30);
        wait_out(1, lat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_head_valid: got %0b required 1", out_valid); end
        for (int i = 0; i < 4; i++) issue(3'd2, 4'd3, 1'b1, 4'd0, 1'b0, exp_tag[i]);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_in_ready: got %0b required 0", in_ready); end
        step();
        checks++; if (full_oc_ib !== 1'b1) begin errors++; $display("[TB] FAIL b2b_full_oc_ib: got %0b required 1", full_oc_ib); end
        in_valid      = 1'b1;
        in_warp       = 3'd2;
        in_src1       = 4'd3;
        in_src1_valid = 1'b1;
        in_src2_valid = 1'b0;
        in_tag        = exp_tag[4];
        for (int i = 0; i < 8; i++) step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fifth_held: in_ready %0b required 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_tag !== 64'h30) begin errors++; $display("[TB] FAIL b2b_hold: valid %0b tag %0h required 1 tag 30", out_valid, out_tag); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) begin
                in_valid      = 1'b0;
                in_src1_valid = 1'b0;
            end
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reassert: in_ready %0b required 1", in_ready); end
            end
            checks++;
            if (out_valid !== 1'b1 || out_tag !== exp_tag[i]) begin
                errors++;
                $display("[TB] FAIL b2b_order_%0d: valid %0b tag %0h required 1 tag %0h", i, out_valid, out_tag, exp_tag[i]);
            end
        end
        checks++; if (out_data1 !== rep(32'h3)) begin errors++; $display("[TB] FAIL b2b_data: got %0h required %0h", out_data1, rep(32'h3)); end
        step();
        step();
    endtask

    task automatic test_writeback();
        int lat;
        logic saw;
        logic [DW-1:0] exp;
        wb_write(3'd1, 4'd0, 8'hFF, lanes_from(32'h100));
        wb_write(3'd1, 4'd0, 8'h0F, lanes_from(32'h200));
        for (int l = 0; l < LANES; l++) exp[l*32 +: 32] = (l < 4) ? 32'h200 + 32'(l) : 32'h100 + 32'(l);
        wb_valid = 1'b1;
        wb_warp  = 3'd0;
        wb_reg   = 4'd5;
        wb_mask  = 8'hFF;
        wb_data  = rep(32'h5);
        issue(3'd1, 4'd0, 1'b1, 4'd0, 1'b0, 64'h44);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) saw = 1'b1;
            step();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL wb_stall: out_valid seen %0b required 0", saw); end
        wb_valid = 1'b0;
        wait_out(0, lat);
        checks++; if (lat != 2) begin errors++; $display("[TB] FAIL wb_release_latency: got %0d required 2", lat); end
        checks++; if (out_data1 !== exp) begin errors++; $display("[TB] FAIL wb_masked_data: got %0h required %0h", out_data1, exp); end
        checks++; if (out_tag !== 64'h44) begin errors++; $display("[TB] FAIL wb_tag: got %0h required 44", out_tag); end
        step();
    endtask

    task automatic test_same_src();
        int lat;
        wb_write(3'd3, 4'd5, 8'hFF, rep(32'h55));
        issue(3'd3, 4'd5, 1'b1, 4'd5, 1'b1, 64'h55);
        wait_out(1, lat);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL same_src_latency: got %0d required 3", lat); end
        checks++; if (out_data1 !== rep(32'h55)) begin errors++; $display("[TB] FAIL same_src_data1: got %0h required %0h", out_data1, rep(32'h55)); end
        checks++; if (out_data2 !== rep(32'h55)) begin errors++; $display("[TB] FAIL same_src_data2: got %0h required %0h", out_data2, rep(32'h55)); end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b0;
        issue(3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 64'h60);
        wait_out(1, lat);
        wb_valid = 1'b1;
        wb_warp  = 3'd0;
        wb_reg   = 4'd9;
        wb_mask  = 8'hFF;
        wb_data  = rep(32'h9);
        for (int i = 0; i < 3; i++) issue(3'd0, 4'd5, 1'b1, 4'd0, 1'b0, 64'h61 + 64'(i));
        step();
        checks++; if (out_valid !== 1'b1 || out_tag !== 64'h60) begin errors++; $display("[TB] FAIL rst_mid_pre: valid %0b tag %0h required 1 tag 60", out_valid, out_tag); end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready: got %0b required 1", in_ready); end
        checks++; if (out_tag !== '0) begin errors++; $display("[TB] FAIL rst_mid_out_tag: got %0h required 0", out_tag); end
        rst       = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        issue(3'd2, 4'd3, 1'b1, 4'd0, 1'b0, 64'h66);
        wait_out(1, lat);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL rst_fresh_latency: got %0d required 3", lat); end
        checks++; if (out_tag !== 64'h66 || out_data1 !== rep(32'h3)) begin errors++; $display("[TB] FAIL rst_fresh_out: tag %0h data %0h required 66 / %0h", out_tag, out_data1, rep(32'h3)); end
        step();
        checks++; if (full_oc_ib !== 1'b0) begin errors++; $display("[TB] FAIL rst_fresh_full: got %0b required 0", full_oc_ib); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_warp       = '0;
        in_src1       = '0;
        in_src2       = '0;
        in_src1_valid = 1'b0;
        in_src2_valid = 1'b0;
        in_tag        = '0;
        wb_valid      = 1'b0;
        wb_warp       = '0;
        wb_reg        = '0;
        wb_mask       = '0;
        wb_data       = '0;
        out_ready     = 1'b1;
        #1;
        test_reset();
        test_single_src();
        test_bank_conflict();
        test_same_src();
        test_writeback();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
